// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the processor memory-side arbiters.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 16;

  // Port identifiers; also used as indices into 2-bit request/grant vectors.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_D = 1'b1
  } arb_state_e;

  // Which port owns the response slot in the cycle after a transfer.
  typedef struct packed {
    logic valid;
    logic port;
    logic we;
  } rsp_sel_t;

endpackage

// File: rtl/unified_mem_arbiter_rr_grant2.sv
// Two-way round-robin grant with an override that restricts the grant to D.
module rr_grant2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_d,
  output logic [1:0] gnt
);

  // Grant one requester; on a tie, the port that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (force_d) begin
      gnt[PORT_D] = req[PORT_D];
    end else if (&req) begin
      if (last == PORT_D) begin
        gnt[PORT_I] = 1'b1;
      end else begin
        gnt[PORT_D] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and
// load/store (D), with round-robin arbitration and a D-side lock.
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [BE_W-1:0]   d_req_be,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic              d_req_lock,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  rsp_sel_t         rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req;
  logic [1:0]       gnt;

  // Requests are masked while reset is high so nothing is granted or strobed.
  assign req = {d_req_valid, i_req_valid} & {2{~reset}};

  rr_grant2 u_rr_grant2 (
    .req     (req),
    .last    (last_q),
    .force_d (state_q == LOCK_D),
    .gnt     (gnt)
  );

  assign i_req_ready = gnt[PORT_I];
  assign d_req_ready = gnt[PORT_D];

  // Steer the granted port onto the RAM; idle fields are driven to zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[PORT_D]) begin
      mem_en    = 1'b1;
      mem_we    = d_req_we;
      mem_be    = d_req_be;
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
    end else if (gnt[PORT_I]) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = i_req_addr;
    end
  end

  // Next-state: lock FSM, round-robin history, response slot, conflict counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rsp_d   = '0;
    cnt_d   = cnt_q;
    if (gnt[PORT_D]) begin
      last_d  = PORT_D;
      state_d = d_req_lock ? LOCK_D : ARB;
      rsp_d   = '{valid: 1'b1, port: PORT_D, we: d_req_we};
    end else if (gnt[PORT_I]) begin
      last_d  = PORT_I;
      rsp_d   = '{valid: 1'b1, port: PORT_I, we: 1'b0};
    end
    if (i_req_valid && d_req_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any pending response and clears the lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= PORT_D;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fixed one-cycle response: RAM read data routed to the port that owned the access.
  assign i_rsp_valid  = rsp_q.valid && (rsp_q.port == PORT_I) && !reset;
  assign d_rsp_valid  = rsp_q.valid && (rsp_q.port == PORT_D) && !reset;
  assign i_rsp_rdata  = i_rsp_valid ? mem_rdata : '0;
  assign d_rsp_rdata  = (d_rsp_valid && !rsp_q.we) ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_req_lock, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_be;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_req_lock(d_req_lock), .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Transaction-level model: who owns the memory this cycle, who gets data next.
  bit locked;      // D holds the memory
  int last_win;    // 0 = I, 1 = D
  int win;         // winner in the current cycle, -1 = nobody
  bit pend;        // a response is due this cycle
  int pend_port;
  bit pend_store;
  int conflicts;

  function automatic void model_reset();
    locked     = 1'b0;
    last_win   = 1;
    win        = -1;
    pend       = 1'b0;
    pend_port  = 0;
    pend_store = 1'b0;
    conflicts  = 0;
  endfunction

  initial model_reset();

  // Compare process: outputs checked away from the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      win = -1;
      chk("rst_i_ready", i_req_ready, 0);
      chk("rst_d_ready", d_req_ready, 0);
      chk("rst_i_rsp_valid", i_rsp_valid, 0);
      chk("rst_d_rsp_valid", d_rsp_valid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
    end else begin
      if (locked)                          win = d_req_valid ? 1 : -1;
      else if (i_req_valid && d_req_valid) win = 1 - last_win;
      else if (i_req_valid)                win = 0;
      else if (d_req_valid)                win = 1;
      else                                 win = -1;

      chk("i_req_ready", i_req_ready, win == 0);
      chk("d_req_ready", d_req_ready, win == 1);
      chk("mem_en", mem_en, win >= 0);
      chk("mem_we", mem_we, (win == 1) ? d_req_we : 1'b0);
      chk("mem_be", mem_be, (win == 1) ? d_req_be : (win == 0) ? 4'hF : 4'h0);
      chk("mem_addr", mem_addr, (win == 1) ? d_req_addr : (win == 0) ? i_req_addr : 32'h0);
      chk("mem_wdata", mem_wdata, (win == 1) ? d_req_wdata : 32'h0);

      chk("i_rsp_valid", i_rsp_valid, pend && pend_port == 0);
      chk("d_rsp_valid", d_rsp_valid, pend && pend_port == 1);
      chk("rsp_exclusive", i_rsp_valid & d_rsp_valid, 0);
      if (pend && pend_port == 0) chk("i_rsp_rdata", i_rsp_rdata, mem_rdata);
      if (pend && pend_port == 1) chk("d_rsp_rdata", d_rsp_rdata, pend_store ? 32'h0 : mem_rdata);
      chk("conflict_cnt", conflict_cnt, conflicts);
    end
  end

  // Model update at each rising edge using the winner decided for that cycle.
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      if (i_req_valid && d_req_valid && conflicts < 65535) conflicts++;
      pend       = (win >= 0);
      pend_port  = win;
      pend_store = (win == 1) && d_req_we;
      if (win == 1) locked = d_req_lock;
      if (win >= 0) last_win = win;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  bit i_acc, d_acc;

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_we = 1'b0; d_req_be = 4'h0;
    d_req_wdata = 32'h0; d_req_lock = 1'b0;
    mem_rdata = 32'h0;

    // Reset held with both requesters active.
    repeat (5) @(negedge clk);
    chk("lit_rst_ready", {i_req_ready, d_req_ready}, 2'b00);
    chk("lit_rst_mem_en", mem_en, 0);

    // I-only read.
    next_cycle();
    reset = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h0000_0004; d_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_iread_ready", i_req_ready, 1);
    chk("lit_iread_addr", mem_addr, 32'h4);
    next_cycle();
    i_req_valid = 1'b0; mem_rdata = 32'h00A0_0093;
    @(negedge clk);
    chk("lit_iread_rsp", {i_rsp_valid, d_rsp_valid, i_rsp_rdata}, {2'b10, 32'h00A0_0093});

    // D store.
    next_cycle();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'b0011;
    d_req_wdata = 32'hDEAD_BEEF; d_req_addr = 32'h200;
    @(negedge clk);
    chk("lit_store_mem", {mem_en, mem_we, mem_be, mem_wdata}, {2'b11, 4'b0011, 32'hDEAD_BEEF});
    next_cycle();
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = 4'h0; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("lit_store_ack", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'h0});

    // Tie for four cycles: I, D, I, D.
    next_cycle();
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_tie_grant", {i_req_ready, d_req_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k < 3) next_cycle();
    end
    next_cycle();
    i_req_valid = 1'b0; d_req_valid = 1'b0; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    chk("lit_tie_cnt", conflict_cnt, 16'd4);
    chk("lit_tie_last_rsp", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'h55});

    // Lock: locked load, two idle D cycles, unlocking store, I waiting throughout.
    next_cycle();
    d_req_valid = 1'b1; d_req_lock = 1'b1; d_req_addr = 32'h300;
    @(negedge clk);
    chk("lit_lock_load", d_req_ready, 1);
    next_cycle();
    d_req_valid = 1'b0; d_req_lock = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h80;
    @(negedge clk);
    chk("lit_lock_idle1", {i_req_ready, mem_en}, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("lit_lock_idle2", {i_req_ready, mem_en}, 2'b00);
    next_cycle();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'hF; d_req_wdata = 32'h1; d_req_addr = 32'h304;
    @(negedge clk);
    chk("lit_unlock_store", {i_req_ready, d_req_ready}, 2'b01);
    next_cycle();
    d_req_valid = 1'b0; d_req_we = 1'b0;
    @(negedge clk);
    chk("lit_after_unlock", i_req_ready, 1);
    next_cycle();
    i_req_valid = 1'b0;

    // Reset the cycle after an I transfer.
    next_cycle();
    i_req_valid = 1'b1; i_req_addr = 32'h44;
    @(negedge clk);
    chk("lit_mid_xfer", i_req_ready, 1);
    next_cycle();
    i_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("lit_mid_rst_rsp", i_rsp_valid, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_rsp", i_rsp_valid, 0);
    next_cycle();
    i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h108;
    @(negedge clk);
    chk("lit_post_rst_tie", {i_req_ready, d_req_ready}, 2'b10);
    next_cycle();
    i_req_valid = 1'b0; d_req_valid = 1'b0;

    // Randomized traffic; requesters hold their request until it is accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      i_acc = i_req_valid && i_req_ready;
      d_acc = d_req_valid && d_req_ready;
      next_cycle();
      mem_rdata = $urandom;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (!i_req_valid || i_acc) begin
        i_req_valid = ($urandom_range(0, 99) < 60);
        i_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req_valid || d_acc) begin
        d_req_valid = ($urandom_range(0, 99) < 60);
        d_req_addr  = $urandom;
        d_req_we    = $urandom_range(0, 1) == 1;
        d_req_be    = 4'($urandom);
        d_req_wdata = $urandom;
        d_req_lock  = ($urandom_range(0, 99) < 30);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
